// File: rtl/mul_byte_sequencer.sv
// Byte-serial operand loader and result unloader for the 8x8 combinational multiplier.
// Two operand bytes in, two product bytes out, one capture cycle in between.
module mul_byte_sequencer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_prod,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  op_count
);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, CAPTURE, SEND_0, SEND_1} state_t;

  state_t      state, state_nxt;
  logic [15:0] p;
  logic [7:0]  byte_first, byte_second;
  logic        load_a, load_b, capture, done;

  assign byte_first  = LSB_FIRST ? p[7:0]  : p[15:8];
  assign byte_second = LSB_FIRST ? p[15:8] : p[7:0];

  // in_ready is held low while rst is asserted so no byte is taken in the reset cycle
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    load_a    = 1'b0;
    load_b    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      LOAD_A: begin
        busy     = 1'b0;
        in_ready = !rst;
        if (in_valid && !rst) begin
          load_a    = 1'b1;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load_b    = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = SEND_0;
      end
      SEND_0: begin
        out_valid = 1'b1;
        out_data  = byte_first;
        if (out_ready) state_nxt = SEND_1;
      end
      SEND_1: begin
        out_valid = 1'b1;
        out_data  = byte_second;
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = LOAD_A;
        end
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_A;
      mul_a    <= '0;
      mul_b    <= '0;
      p        <= '0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_a)  mul_a    <= in_data;
      if (load_b)  mul_b    <= in_data;
      if (capture) p        <= mul_prod;
      if (done)    op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mul_byte_sequencer.sv
// Bench for mul_byte_sequencer: two instances (LSB-first and MSB-first) checked every
// cycle against a transaction-level model, plus directed vectors with literal results.
module tb_mul_byte_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_data [2];
  logic [1:0]  in_valid;
  logic [1:0]  out_ready;

  logic        in_ready0, out_valid0, busy0;
  logic        in_ready1, out_valid1, busy1;
  logic [7:0]  mul_a0, mul_b0, out_data0, op_count0;
  logic [7:0]  mul_a1, mul_b1, out_data1, op_count1;
  logic [15:0] mul_prod0, mul_prod1;

  // stand-ins for the combinational multiplier
  assign mul_prod0 = 16'(mul_a0) * 16'(mul_b0);
  assign mul_prod1 = 16'(mul_a1) * 16'(mul_b1);

  mul_byte_sequencer #(.LSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready0),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_prod(mul_prod0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready[0]),
    .busy(busy0), .op_count(op_count0)
  );

  mul_byte_sequencer #(.LSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_prod(mul_prod1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready[1]),
    .busy(busy1), .op_count(op_count1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: operand bytes held, capture gap, product bytes still to deliver
  logic [7:0]  m_ma   [2];
  logic [7:0]  m_mb   [2];
  logic [7:0]  m_cnt  [2];
  int          m_held [2];
  logic        m_gap  [2];
  logic [15:0] m_prod [2];
  int          m_left [2];

  logic [7:0]  got   [2][2];
  int          got_n [2];

  task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, act, exp);
    end
  endtask

  task automatic model_step(input int d, input logic ir, input logic ov, input logic [7:0] od,
                            input logic [7:0] ma, input logic [7:0] mb, input logic bz,
                            input logic [7:0] cnt);
    logic       e_ir, e_ov, e_bz, lsb;
    logic [7:0] e_od, lo, hi;
    lsb  = (d == 0);
    lo   = m_prod[d][7:0];
    hi   = m_prod[d][15:8];
    e_ov = (m_left[d] > 0);
    e_ir = !rst && !m_gap[d] && !e_ov;
    e_bz = (m_held[d] != 0) || m_gap[d] || e_ov;
    if (m_left[d] == 2) e_od = lsb ? lo : hi;
    else                e_od = lsb ? hi : lo;

    chk("in_ready",  d, 16'(ir),  16'(e_ir));
    chk("out_valid", d, 16'(ov),  16'(e_ov));
    chk("busy",      d, 16'(bz),  16'(e_bz));
    chk("mul_a",     d, 16'(ma),  16'(m_ma[d]));
    chk("mul_b",     d, 16'(mb),  16'(m_mb[d]));
    chk("op_count",  d, 16'(cnt), 16'(m_cnt[d]));
    if (e_ov) chk("out_data", d, 16'(od), 16'(e_od));

    if (ov && out_ready[d] && !rst && got_n[d] < 2) begin
      got[d][got_n[d]] = od;
      got_n[d]++;
    end

    if (rst) begin
      m_ma[d] = '0; m_mb[d] = '0; m_cnt[d] = '0;
      m_held[d] = 0; m_gap[d] = 1'b0; m_prod[d] = '0; m_left[d] = 0;
    end else if (m_gap[d]) begin
      m_gap[d]  = 1'b0;
      m_left[d] = 2;
    end else if (m_left[d] > 0) begin
      if (out_ready[d]) begin
        m_left[d]--;
        if (m_left[d] == 0) m_cnt[d] = m_cnt[d] + 8'd1;
      end
    end else if (in_valid[d]) begin
      if (m_held[d] == 0) begin
        m_ma[d]   = in_data[d];
        m_held[d] = 1;
      end else begin
        m_mb[d]   = in_data[d];
        m_prod[d] = 16'(m_ma[d]) * 16'(in_data[d]);
        m_held[d] = 0;
        m_gap[d]  = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, in_ready0, out_valid0, out_data0, mul_a0, mul_b0, busy0, op_count0);
    model_step(1, in_ready1, out_valid1, out_data1, mul_a1, mul_b1, busy1, op_count1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input int d, input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    in_data[d]  = b;
    in_valid[d] = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = (d == 0) ? in_ready0 : in_ready1;
      tick();
    end
    in_valid[d] = 1'b0;
    chk("input_accept_timeout", d, 16'(ok), 16'd1);
  endtask

  task automatic wait_out(input int d, input int n);
    for (int t = 0; t < 100 && got_n[d] < n; t++) tick();
    chk("output_timeout", d, 16'(got_n[d] >= n), 16'd1);
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e0, input logic [7:0] e1, input string name);
    got_n[d] = 0;
    put_byte(d, a);
    put_byte(d, b);
    chk({name, "_gap_valid"}, d, 16'((d == 0) ? out_valid0 : out_valid1), 16'd0);
    tick();
    chk({name, "_first_valid"}, d, 16'((d == 0) ? out_valid0 : out_valid1), 16'd1);
    wait_out(d, 2);
    chk({name, "_byte0"}, d, 16'(got[d][0]), 16'(e0));
    chk({name, "_byte1"}, d, 16'(got[d][1]), 16'(e1));
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] rp;
    rst = 1'b1;
    in_valid = '0;
    out_ready = 2'b11;
    in_data[0] = '0;
    in_data[1] = '0;
    for (int d = 0; d < 2; d++) begin
      m_ma[d] = '0; m_mb[d] = '0; m_cnt[d] = '0; m_held[d] = 0;
      m_gap[d] = 1'b0; m_prod[d] = '0; m_left[d] = 0; got_n[d] = 0;
    end

    // reset state
    tick();
    @(negedge clk);
    chk("rst_in_ready",  0, 16'(in_ready0),  16'd0);
    chk("rst_out_valid", 0, 16'(out_valid0), 16'd0);
    chk("rst_busy",      0, 16'(busy0),      16'd0);
    chk("rst_op_count",  0, 16'(op_count0),  16'd0);
    chk("rst_mul_a",     0, 16'(mul_a0),     16'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 0, 16'(in_ready0), 16'd1);
    tick();

    run_op(0, 8'h0C, 8'h05, 8'h3C, 8'h00, "basic");
    chk("basic_op_count", 0, 16'(op_count0), 16'd1);

    run_op(0, 8'hFF, 8'hFF, 8'h01, 8'hFE, "max_ff");
    run_op(0, 8'hF0, 8'h0F, 8'h10, 8'h0E, "f0x0f");
    chk("max_op_count", 0, 16'(op_count0), 16'd3);

    // backpressure in SEND_0, with a stray input byte offered meanwhile
    out_ready[0] = 1'b0;
    got_n[0] = 0;
    put_byte(0, 8'hAA);
    put_byte(0, 8'h55);
    tick();
    in_data[0]  = 8'h99;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 0, 16'(out_valid0), 16'd1);
      chk("bp_out_data",  0, 16'(out_data0),  16'h72);
      chk("bp_in_ready",  0, 16'(in_ready0),  16'd0);
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    wait_out(0, 2);
    chk("bp_byte0", 0, 16'(got[0][0]), 16'h72);
    chk("bp_byte1", 0, 16'(got[0][1]), 16'h38);
    chk("bp_mul_a_kept", 0, 16'(mul_a0), 16'hAA);
    chk("bp_op_count", 0, 16'(op_count0), 16'd4);

    // MSB-first instance: 0xAB * 0xCD = 0x88EF
    run_op(1, 8'hAB, 8'hCD, 8'h88, 8'hEF, "msb_first");
    chk("msb_op_count", 1, 16'(op_count1), 16'd1);

    // reset with only A loaded
    put_byte(0, 8'h1F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_op(0, 8'h0F, 8'h1F, 8'hD1, 8'h01, "rst_midop");
    chk("rst_midop_op_count", 0, 16'(op_count0), 16'd1);
    chk("rst_midop_mul_a", 0, 16'(mul_a0), 16'h0F);

    // 256 back-to-back operations from a clean reset wrap op_count to zero
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rp = 16'(ra) * 16'(rb);
      run_op(0, ra, rb, rp[7:0], rp[15:8], "wrap");
    end
    chk("wrap_op_count", 0, 16'(op_count0), 16'd0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
